weight_update_ctrl: RTL and testbench

//   Sequences and shares one weight RAM (negedge-clocked, 1-cycle registered read, per-column row storage).

---
 rtl/weight_update_ctrl_if.sv | 40 ++++
 rtl/weight_update_ctrl.sv | 125 ++++++++++++
 tb/tb_weight_update_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_update_ctrl_if.sv
// Bundle of the controller's handshake, forward-read and weight RAM signals.
// The master side is the surrounding datapath; the slave side is the controller.
interface weight_update_ctrl_if #(
   parameter int NROW     = 16,
   parameter int NCOL     = 16,
   parameter int BITWIDTH = 18,
   parameter int AW       = (NCOL > 1) ? $clog2(NCOL) : 1,
   parameter int RW       = BITWIDTH * NROW
);
   logic          start;
   logic          busy;
   logic          done;
   logic          grad_valid;
   logic          grad_ready;
   logic [RW-1:0] grad_row;
   logic          fwd_req;
   logic [AW-1:0] fwd_addr;
   logic          fwd_gnt;
   logic          fwd_valid;
   logic [RW-1:0] fwd_row;
   logic          ram_we;
   logic [AW-1:0] ram_addr_in;
   logic [RW-1:0] ram_row_in;
   logic [AW-1:0] ram_addr_out;
   logic [RW-1:0] ram_row_out;

   modport master (
      output start, grad_valid, grad_row, fwd_req, fwd_addr,
      output ram_row_out,
      input  busy, done, grad_ready, fwd_gnt, fwd_valid, fwd_row,
      input  ram_we, ram_addr_in, ram_row_in, ram_addr_out
   );

   modport slave (
      input  start, grad_valid, grad_row, fwd_req, fwd_addr,
      input  ram_row_out,
      output busy, done, grad_ready, fwd_gnt, fwd_valid, fwd_row,
      output ram_we, ram_addr_in, ram_row_in, ram_addr_out
   );
endinterface

// File: rtl/weight_update_ctrl.sv
// Shares one weight RAM between forward-pass row reads and an SGD sweep
// that applies W := sat(W - (G >>> LR_SHIFT)) column by column.
module weight_update_ctrl #(
   parameter int NROW     = 16,
   parameter int NCOL     = 16,
   parameter int BITWIDTH = 18,
   parameter int LR_SHIFT = 4
) (
   input logic               clk,
   input logic               reset,
   weight_update_ctrl_if.slave bus_io
);
   localparam int AW = (NCOL > 1) ? $clog2(NCOL) : 1;
   localparam int RW = BITWIDTH * NROW;
   localparam int B  = BITWIDTH;

   localparam logic [B-1:0] MAXV = {1'b0, {(B-1){1'b1}}};
   localparam logic [B-1:0] MINV = {1'b1, {(B-1){1'b0}}};
   localparam logic [AW-1:0] LAST = AW'(NCOL - 1);

   typedef enum logic [2:0] {
      IDLE, RD, GRAD, WR, DONE
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] col_q, col_d;
   logic [RW-1:0] upd_q, upd_d;
   logic          fwd_valid_q;
   logic          fwd_gnt;
   logic [RW-1:0] sat_row;

   for (genvar i = 0; i < NROW; i++) begin : g_elem
      logic signed [B-1:0] w;
      logic signed [B-1:0] g;
      logic signed [B-1:0] step;
      logic signed [B:0]   diff;

      assign w    = bus_io.ram_row_out[i*B +: B];
      assign g    = bus_io.grad_row[i*B +: B];
      assign step = g >>> LR_SHIFT;
      assign diff = {w[B-1], w} - {step[B-1], step};

      // Top two bits disagree only when the difference left the B-bit range
      assign sat_row[i*B +: B] =
         (diff[B] != diff[B-1]) ? (diff[B] ? MINV : MAXV)
                                : diff[B-1:0];
   end

   always_comb begin
      state_d             = state_q;
      col_d               = col_q;
      upd_d               = upd_q;
      fwd_gnt             = 1'b0;
      bus_io.grad_ready   = 1'b0;
      bus_io.ram_we       = 1'b0;
      bus_io.ram_addr_in  = '0;
      bus_io.ram_row_in   = '0;
      bus_io.ram_addr_out = '0;

      unique case (state_q)
         IDLE: begin
            if (bus_io.start) begin
               state_d = RD;
               col_d   = '0;
            end else if (bus_io.fwd_req && !reset) begin
               fwd_gnt             = 1'b1;
               bus_io.ram_addr_out = bus_io.fwd_addr;
            end
         end
         RD: begin
            bus_io.ram_addr_out = col_q;
            state_d             = GRAD;
         end
         GRAD: begin
            bus_io.ram_addr_out = col_q;
            bus_io.grad_ready   = 1'b1;
            if (bus_io.grad_valid) begin
               upd_d   = sat_row;
               state_d = WR;
            end
         end
         WR: begin
            // Gated so an aborting reset never lands a partial write
            bus_io.ram_we      = !reset;
            bus_io.ram_addr_in = col_q;
            bus_io.ram_row_in  = upd_q;
            if (col_q == LAST) begin
               state_d = DONE;
            end else begin
               col_d   = col_q + AW'(1);
               state_d = RD;
            end
         end
         DONE: begin
            state_d = IDLE;
            col_d   = '0;
         end
         default: begin
            state_d = IDLE;
            col_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         col_q       <= '0;
         upd_q       <= '0;
         fwd_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         upd_q       <= upd_d;
         fwd_valid_q <= fwd_gnt;
      end
   end

   assign bus_io.busy      = (state_q != IDLE);
   assign bus_io.done      = (state_q == DONE);
   assign bus_io.fwd_gnt   = fwd_gnt;
   assign bus_io.fwd_valid = fwd_valid_q;
   assign bus_io.fwd_row   = bus_io.ram_row_out;

endmodule

// File: tb/tb_weight_update_ctrl.sv
// Directed bench for weight_update_ctrl with a negedge-clocked RAM model.
// Vector table for the update arithmetic plus hand sequences for timing cases.
module tb_weight_update_ctrl;
   localparam int B  = 18;
   localparam int NR = 4;
   localparam int NC = 4;
   localparam int AW = 2;
   localparam int RW = B * NR;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   weight_update_ctrl_if #(.NROW(NR), .NCOL(NC), .BITWIDTH(B)) wif ();

   weight_update_ctrl #(
      .NROW(NR), .NCOL(NC), .BITWIDTH(B), .LR_SHIFT(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus_io(wif.slave)
   );

   logic [RW-1:0] mem [NC];
   logic [RW-1:0] pre_rows [NC];
   logic          pre_go = 1'b0;
   logic [RW-1:0] rd_q = '0;
   logic [AW-1:0] wr_addr [64];
   int            wr_cnt = 0;

   assign wif.ram_row_out = rd_q;

   // RAM model: reset clears, but a write in the same edge still lands
   always @(negedge clk) begin
      if (pre_go)
         for (int r = 0; r < NC; r++) mem[r] <= pre_rows[r];
      if (reset)
         for (int r = 0; r < NC; r++) mem[r] <= '0;
      if (wif.ram_we) begin
         mem[wif.ram_addr_in] <= wif.ram_row_in;
         wr_addr[wr_cnt[5:0]] <= wif.ram_addr_in;
         wr_cnt               <= wr_cnt + 1;
      end
      rd_q <= mem[wif.ram_addr_out];
   end

   typedef struct {
      logic [B-1:0] w;
      logic [B-1:0] g;
      logic [B-1:0] e;
   } vec_t;

   vec_t vt [9];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [RW-1:0] act,
                      input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] rep(input logic [B-1:0] v);
      logic [RW-1:0] r;
      for (int i = 0; i < NR; i++) r[i*B +: B] = v;
      return r;
   endfunction

   task automatic preload();
      pre_go = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      pre_go = 1'b0;
   endtask

   // Entry and exit at posedge+1; start is sampled at the end of cycle 0
   task automatic sweep(input int sc, input int sn, input int rs,
                        output int dc);
      bit stall;
      dc = -1;
      wif.start = 1'b1;
      for (int c = 0; c < 200; c++) begin
         stall = (sn > 0) && (c >= 2 + 3*sc) && (c < 2 + 3*sc + sn);
         wif.grad_valid = !stall;
         if (c == rs) wif.start = 1'b1;
         @(negedge clk);
         if (stall) begin
            chk($sformatf("stall_addr c%0d", c), wif.ram_addr_out, sc);
            chk($sformatf("stall_we c%0d", c), wif.ram_we, 0);
            chk($sformatf("stall_rdy c%0d", c), wif.grad_ready, 1);
         end
         if (c == 1) chk("busy_c1", wif.busy, 1);
         chk($sformatf("gnt_busy c%0d", c), wif.fwd_gnt, 0);
         if (wif.done && dc < 0) dc = c;
         @(posedge clk);
         #1;
         wif.start = 1'b0;
         if (dc >= 0) break;
      end
      wif.grad_valid = 1'b0;
   endtask

   int dc;
   int base;
   int npulse;

   initial begin
      vt[0] = '{18'h00800, 18'h00100, 18'h007F0};
      vt[1] = '{18'h1FFFF, 18'h20000, 18'h1FFFF};
      vt[2] = '{18'h20000, 18'h1FFFF, 18'h20000};
      vt[3] = '{18'h00000, 18'h3FFFF, 18'h00001};
      vt[4] = '{18'h00000, 18'h0000F, 18'h00000};
      vt[5] = '{18'h00010, 18'h3FF00, 18'h00020};
      vt[6] = '{18'h3FFF0, 18'h00200, 18'h3FFD0};
      vt[7] = '{18'h1FFF0, 18'h3FE00, 18'h1FFFF};
      vt[8] = '{18'h20005, 18'h00100, 18'h20000};

      wif.start      = 1'b0;
      wif.grad_valid = 1'b0;
      wif.grad_row   = '0;
      wif.fwd_req    = 1'b0;
      wif.fwd_addr   = '0;
      for (int r = 0; r < NC; r++) pre_rows[r] = '0;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", wif.busy, 0);
      chk("rst_done", wif.done, 0);
      chk("rst_grdy", wif.grad_ready, 0);
      chk("rst_gnt", wif.fwd_gnt, 0);
      chk("rst_fval", wif.fwd_valid, 0);
      chk("rst_we", wif.ram_we, 0);
      chk("rst_ain", wif.ram_addr_in, 0);
      chk("rst_din", wif.ram_row_in, 0);
      chk("rst_aout", wif.ram_addr_out, 0);
      @(posedge clk);
      #1;

      for (int k = 0; k < 9; k++) begin
         for (int r = 0; r < NC; r++) pre_rows[r] = rep(vt[k].w);
         preload();
         wif.grad_row = rep(vt[k].g);
         base = wr_cnt;
         sweep(0, 0, -1, dc);
         chk($sformatf("v%0d done_cyc", k), dc, 13);
         chk($sformatf("v%0d writes", k), wr_cnt - base, 4);
         for (int r = 0; r < NC; r++) begin
            chk($sformatf("v%0d waddr%0d", k, r),
                wr_addr[(base + r) % 64], r);
            chk($sformatf("v%0d row%0d", k, r), mem[r], rep(vt[k].e));
         end
      end

      // Gradient stalls five cycles in GRAD of column 2
      for (int r = 0; r < NC; r++) pre_rows[r] = rep(18'h00800);
      preload();
      wif.grad_row = rep(18'h00100);
      base = wr_cnt;
      sweep(2, 5, -1, dc);
      chk("stall done_cyc", dc, 18);
      chk("stall writes", wr_cnt - base, 4);
      for (int r = 0; r < NC; r++)
         chk($sformatf("stall row%0d", r), mem[r], rep(18'h007F0));

      // Second start mid-sweep must be ignored
      preload();
      base = wr_cnt;
      sweep(0, 0, 5, dc);
      chk("restart done_cyc", dc, 13);
      @(negedge clk);
      chk("restart idle", wif.busy, 0);
      chk("restart done_low", wif.done, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("restart writes", wr_cnt - base, 4);

      // Forward reads, including back-to-back grants
      for (int r = 0; r < NC; r++) pre_rows[r] = rep(18'(r * 'h111 + 5));
      preload();
      wif.fwd_req  = 1'b1;
      wif.fwd_addr = 2'd3;
      @(negedge clk);
      chk("fwd gnt0", wif.fwd_gnt, 1);
      chk("fwd aout0", wif.ram_addr_out, 3);
      chk("fwd val0", wif.fwd_valid, 0);
      @(posedge clk);
      #1;
      wif.fwd_addr = 2'd1;
      @(negedge clk);
      chk("fwd val1", wif.fwd_valid, 1);
      chk("fwd row3", wif.fwd_row, pre_rows[3]);
      chk("fwd gnt1", wif.fwd_gnt, 1);
      @(posedge clk);
      #1;
      wif.fwd_req = 1'b0;
      @(negedge clk);
      chk("fwd val2", wif.fwd_valid, 1);
      chk("fwd row1", wif.fwd_row, pre_rows[1]);
      chk("fwd gnt2", wif.fwd_gnt, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("fwd val3", wif.fwd_valid, 0);
      @(posedge clk);
      #1;

      // start and fwd_req together: start wins, request held until done
      wif.fwd_req  = 1'b1;
      wif.fwd_addr = 2'd2;
      wif.grad_row = '0;
      sweep(0, 0, -1, dc);
      chk("fwdstart done_cyc", dc, 13);
      @(negedge clk);
      chk("fwdstart gnt_after", wif.fwd_gnt, 1);
      @(posedge clk);
      #1;
      wif.fwd_req = 1'b0;
      @(negedge clk);
      chk("fwdstart val", wif.fwd_valid, 1);
      chk("fwdstart row2", wif.fwd_row, pre_rows[2]);
      @(posedge clk);
      #1;

      // Reset during WR of column 1
      for (int r = 0; r < NC; r++) pre_rows[r] = rep(18'h00800);
      preload();
      wif.grad_row   = rep(18'h00100);
      wif.grad_valid = 1'b1;
      base = wr_cnt;
      wif.start = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         @(posedge clk);
         #1;
         wif.start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      chk("rstwr we", wif.ram_we, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rstwr busy", wif.busy, 0);
      chk("rstwr done", wif.done, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      wif.grad_valid = 1'b0;
      npulse = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (wif.done || wif.busy) npulse++;
         @(posedge clk);
         #1;
      end
      chk("rstwr no_done", npulse, 0);
      chk("rstwr writes", wr_cnt - base, 1);
      for (int r = 0; r < NC; r++) begin
         wif.fwd_req  = 1'b1;
         wif.fwd_addr = AW'(r);
         @(posedge clk);
         #1;
         wif.fwd_req = 1'b0;
         @(negedge clk);
         chk($sformatf("rstwr val%0d", r), wif.fwd_valid, 1);
         chk($sformatf("rstwr row%0d", r), wif.fwd_row, 0);
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
